ycconfig_loader: RTL
====================

// Module: ycconfig_loader
// PURPOSE
// - Transmit end of the Morphle Logic ycconfig shift chain.
// - Takes 3-bit cell codes over a valid/ready handshake and serializes them MSB-first
//   onto cbitout/confclk for a chain of CELLS ycconfig cells.
// - Also reads back the chain's tail output (cbitret) and reassembles it into 3-bit codes,
//   so the previous configuration can be checked while a new one is loaded.
// - Cell codes: space=000 +=001 -=010 |=011 1=100 0=101 Y=110 N=111.
// PARAMETERS
// - CELLS  8  number of ycconfig cells in the chain (codes per frame, >=1)
// - DIV    2  system clocks per confclk phase (>=1)
// PORTS
// - clk       in   1  system clock; all logic on rising edge
// - reset_n   in   1  asynchronous, active-low reset
// - in_valid  in   1  in_code is valid
// - in_code   in   3  cell code to shift; bit 2 is sent first
// - in_ready  out  1  loader can accept a code this cycle
// - confclk   out  1  chain shift clock (registered)
// - cbitout   out  1  serial data into the first chain cell (registered)
// - cbitret   in   1  cbitout of the last chain cell
// - busy      out  1  frame in progress (first code accepted, frame_done not yet pulsed)
// - frame_done out 1  one-cycle pulse after the CELLS-th code is fully shifted
// - rb_valid  out  1  one-cycle pulse: rb_code holds a complete read-back code
// - rb_code   out  3  code that left the chain tail, MSB first as received
// BEHAVIOUR
// - Reset (async, any state): confclk=0, cbitout=0, in_ready=0, busy=0, frame_done=0,
//   rb_valid=0, rb_code=000; state=IDLE; all counters cleared.
// - First clk after reset release: in_ready=1.
// - States: IDLE, WAIT, SETUP, HIGH.
//   - IDLE/WAIT: in_ready=1, confclk=0. WAIT differs only in busy=1.
//   - Accept on in_valid & in_ready.
//     - Latch the code; bit counter b=2; go to SETUP.
//     - Accept in IDLE sets busy.
//   - SETUP (DIV cycles): cbitout=code[b], confclk=0. On its last cycle, sample cbitret into
//     the read-back shifter; then go to HIGH.
//   - HIGH (DIV cycles): confclk=1, cbitout held.
//     - At the end, if b>0: b--, go to SETUP.
//     - Else the code is complete:
//       - Cell counter c = CELLS-1: pulse frame_done, clear busy and c, go to IDLE.
//       - Otherwise: c++, go to WAIT.
// - in_ready=0 in SETUP/HIGH. There is no skid buffer; one code is in flight at most.
// - Timing:
//   - cbitout is valid the cycle after accept.
//   - The first confclk rise is DIV cycles after that.
//   - One code takes exactly 6*DIV cycles from accept to return to WAIT/IDLE.
//   - With in_valid held high, the next code is accepted the cycle the state returns to
//     WAIT, giving 6*DIV+1 cycles per code.
// - Stall: in WAIT with in_valid=0, confclk stays 0 and cbitout holds its last bit
//   indefinitely. The chain is static, so stalls are harmless.
// - cbitout only changes in SETUP's first cycle, while confclk=0. This gives DIV cycles of
//   setup before the rise and DIV cycles of hold after it.
// - Ordering: the first code of a frame ends in the last cell; the last code ends in the
//   first cell.
// - Read-back:
//   - The shifter collects 3 sampled bits MSB-first.
//   - After the 3rd sample, rb_code updates and rb_valid pulses in the cycle after that
//     SETUP's last cycle.
//   - The read-back bit counter is tied to b, so read-back codes stay aligned to cell
//     boundaries.
//   - Frame k's read-back yields frame k-1's codes in the same order they were sent.
//   - The first frame after power-up yields whatever the chain held.
// - in_code and in_valid are ignored while in_ready=0.
// - Reset mid-frame: confclk drops to 0 asynchronously and the partial frame is abandoned.
//   The chain contents are undefined until a full CELLS-code frame is reloaded.
// TESTING
// - CELLS=1, DIV=2, send + (001):
//   - cbitout sequence is 0,0,1.
//   - Exactly 3 confclk pulses, each 2 clk high, each preceded by 2 clk with the bit stable.
//   - frame_done pulses 12 clk after accept.
// - CELLS=8, DIV=1, frame A = space,+,-,|,1,0,Y,N, then frame B = 8x N, with cbitret tied to
//   a model of an 8-cell ycconfig chain:
//   - Frame B's read-back is 000,001,010,011,100,101,110,111 in order.
//   - After frame B, every cell decodes as N.
// - Stall: deassert in_valid for 20 clk after the 3rd code -> confclk stays 0 and cbitout
//   is stable throughout. Resume -> the final chain contents are identical to the unstalled
//   run.
// - Back-to-back: in_valid held high -> accepts are spaced exactly 6*DIV+1 clk apart, busy
//   is high continuously from the 1st accept to frame_done, and frame_done is a single-cycle
//   pulse.
// - Reset: assert reset_n=0 during HIGH of the 2nd bit of code 4 ->
//   - confclk and all outputs go to their reset values immediately, with no clk edge needed.
//   - After release, in_ready=1 on the next clk.
//   - A full reload gives correct contents.
// - Protocol: toggle in_code while in_ready=0 -> the transmitted bits match the code
//   latched at accept.

Source files
------------

// File: rtl/ycconfig_loader.sv
// ycconfig_loader: transmit end of the Morphle Logic ycconfig shift chain.
// Serializes 3-bit cell codes MSB-first onto cbitout/confclk and reassembles
// the bits that fall out of the chain tail (cbitret) into read-back codes.
module ycconfig_loader #(
  parameter int CELLS = 8,
  parameter int DIV   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic       confclk,
  output logic       cbitout,
  input  logic       cbitret,
  output logic       busy,
  output logic       frame_done,
  output logic       rb_valid,
  output logic [2:0] rb_code
);

  localparam int CW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(CELLS - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SETUP, HIGH} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ph_reg, ph_next;          // cycle within a confclk phase
  logic [1:0]    b_reg, b_next;            // bit of the code being sent
  logic [CW-1:0] c_reg, c_next;            // code index within the frame
  logic [2:0]    code_reg, code_next;      // code latched at accept
  logic [1:0]    rb_shift_reg, rb_shift_next;  // first two read-back samples
  logic [2:0]    rb_code_reg, rb_code_next;
  logic          rb_valid_reg, rb_valid_next;
  logic          busy_reg, busy_next;
  logic          frame_done_reg, frame_done_next;
  logic          in_ready_reg, in_ready_next;
  logic          confclk_reg, confclk_next;
  logic          cbitout_reg, cbitout_next;

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_next      = state_reg;
    ph_next         = ph_reg;
    b_next          = b_reg;
    c_next          = c_reg;
    code_next       = code_reg;
    rb_shift_next   = rb_shift_reg;
    rb_code_next    = rb_code_reg;
    rb_valid_next   = 1'b0;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;

    case (state_reg)
      IDLE, WAIT: begin
        // in_ready_reg gates the accept so nothing is taken before the first clock after reset
        if (in_valid && in_ready_reg) begin
          code_next  = in_code;
          b_next     = 2'd2;
          ph_next    = '0;
          busy_next  = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (ph_reg == LAST_PH) begin
          ph_next       = '0;
          state_next    = HIGH;
          // sample the tail bit just before the rising confclk shifts the chain
          rb_shift_next = {rb_shift_reg[0], cbitret};
          if (b_reg == 2'd0) begin
            rb_code_next  = {rb_shift_reg, cbitret};
            rb_valid_next = 1'b1;
          end
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      HIGH: begin
        if (ph_reg == LAST_PH) begin
          ph_next = '0;
          if (b_reg != 2'd0) begin
            b_next     = b_reg - 2'd1;
            state_next = SETUP;
          end else if (c_reg == LAST_CELL) begin
            c_next          = '0;
            busy_next       = 1'b0;
            frame_done_next = 1'b1;
            state_next      = IDLE;
          end else begin
            c_next     = c_reg + 1'b1;
            state_next = WAIT;
          end
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    in_ready_next = (state_next == IDLE) || (state_next == WAIT);
    confclk_next  = (state_next == HIGH);
    // cbitout only moves on entry to SETUP, while confclk is low
    cbitout_next  = cbitout_reg;
    if ((state_next == SETUP) && (state_reg != SETUP)) begin
      cbitout_next = code_next[b_next];
    end
  end

  // State and registered outputs; reset drops confclk without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      ph_reg         <= '0;
      b_reg          <= '0;
      c_reg          <= '0;
      code_reg       <= '0;
      rb_shift_reg   <= '0;
      rb_code_reg    <= '0;
      rb_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      confclk_reg    <= 1'b0;
      cbitout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ph_reg         <= ph_next;
      b_reg          <= b_next;
      c_reg          <= c_next;
      code_reg       <= code_next;
      rb_shift_reg   <= rb_shift_next;
      rb_code_reg    <= rb_code_next;
      rb_valid_reg   <= rb_valid_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      in_ready_reg   <= in_ready_next;
      confclk_reg    <= confclk_next;
      cbitout_reg    <= cbitout_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign confclk    = confclk_reg;
  assign cbitout    = cbitout_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign rb_valid   = rb_valid_reg;
  assign rb_code    = rb_code_reg;

endmodule
